// File: rtl/alu_sequencer.sv
// Command sequencer for the 8-bit ALU: single-pass ops in one EXEC cycle,
// MUL (low byte) as eight shift-add passes, results returned over valid/ready.
module alu_sequencer #(
    parameter int W         = 8,
    parameter int MUL_STEPS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_add,
    output logic         alu_inc,
    output logic         alu_neg,
    output logic         alu_sub,
    input  logic [W-1:0] alu_out,
    input  logic         alu_z,
    input  logic         alu_n,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_z,
    output logic         rsp_n,
    output logic         rsp_err,
    output logic         busy
);
    localparam int CW = $clog2(MUL_STEPS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_STEPS - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, MUL_STEP, RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  opa_q, opa_d;   // operand A; multiplicand m during MUL
    logic [W-1:0]  opb_q, opb_d;   // operand B; multiplier q during MUL
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_z_q, rsp_z_d;
    logic          rsp_n_q, rsp_n_d;
    logic          rsp_err_q, rsp_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_z_q    <= 1'b0;
            rsp_n_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_z_q    <= rsp_z_d;
            rsp_n_q    <= rsp_n_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_z_d    = rsp_z_q;
        rsp_n_d    = rsp_n_q;
        rsp_err_d  = rsp_err_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_add    = 1'b0;
        alu_inc    = 1'b0;
        alu_neg    = 1'b0;
        alu_sub    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    opa_d   = cmd_a;
                    opb_d   = cmd_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (cmd_op == OP_MUL) ? MUL_STEP : EXEC;
                end
            end
            EXEC: begin
                alu_a = opa_q;
                alu_b = opb_q;
                case (op_q)
                    OP_ADD:  alu_add = 1'b1;
                    OP_SUB:  alu_sub = 1'b1;
                    OP_INC:  alu_inc = 1'b1;
                    OP_NEG:  alu_neg = 1'b1;
                    default: ;
                endcase
                if (op_q <= OP_NEG) begin
                    rsp_data_d = alu_out;
                    rsp_z_d    = alu_z;
                    rsp_n_d    = alu_n;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_data_d = '0;
                    rsp_z_d    = 1'b0;
                    rsp_n_d    = 1'b0;
                    rsp_err_d  = 1'b1;
                end
                state_d = RESP;
            end
            MUL_STEP: begin
                alu_a   = acc_q;
                alu_b   = opa_q;
                alu_add = 1'b1;
                if (opb_q[0]) acc_d = alu_out;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // flags come from the finished product, not the ALU's last pass
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = acc_d;
                    rsp_z_d    = (acc_d == '0);
                    rsp_n_d    = acc_d[W-1];
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus an arithmetic
// reference for each opcode; directed cases followed by random commands.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_add, alu_inc, alu_neg, alu_sub, alu_z, alu_n;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_z, rsp_n, rsp_err, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_add(alu_add), .alu_inc(alu_inc),
        .alu_neg(alu_neg), .alu_sub(alu_sub),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural 8-bit ALU
    always_comb begin
        alu_out = 8'h00;
        if (alu_add)      alu_out = alu_a + alu_b;
        else if (alu_sub) alu_out = alu_b - alu_a;
        else if (alu_inc) alu_out = alu_b + 8'd1;
        else if (alu_neg) alu_out = 8'd0 - alu_a;
    end
    assign alu_z = (alu_out == 8'h00);
    assign alu_n = alu_out[7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_data(input logic [2:0] op, input int a, input int b);
        case (op)
            3'd0:    return (a + b) % 256;
            3'd1:    return (b - a + 256) % 256;
            3'd2:    return (b + 1) % 256;
            3'd3:    return (256 - a) % 256;
            3'd4:    return (a * b) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input bit poke);
        int wt, lat, ca, cs, ci, cn, ed;
        logic [7:0] held;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        wt = 0;
        while (!cmd_ready && wt < 50) begin @(negedge clk); wt++; end
        chk("accept_wait", wt, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        lat = 1; ca = 0; cs = 0; ci = 0; cn = 0;
        while (!rsp_valid && lat < 20) begin
            ca += int'(alu_add); cs += int'(alu_sub); ci += int'(alu_inc); cn += int'(alu_neg);
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, (op == 3'd4) ? 9 : 2);
        chk("add_cycles", ca, (op == 3'd0) ? 1 : (op == 3'd4) ? 8 : 0);
        chk("sub_cycles", cs, (op == 3'd1) ? 1 : 0);
        chk("inc_cycles", ci, (op == 3'd2) ? 1 : 0);
        chk("neg_cycles", cn, (op == 3'd3) ? 1 : 0);
        ed = ref_data(op, a, b);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, (op > 3'd4) ? 1 : 0);
        chk("rsp_z", rsp_z, (op <= 3'd4 && ed == 0) ? 1 : 0);
        chk("rsp_n", rsp_n, (op <= 3'd4) ? (ed >> 7) & 1 : 0);
        chk("resp_alu_quiet", {alu_add, alu_inc, alu_neg, alu_sub, alu_a, alu_b}, 0);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke) begin
                cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            end
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, held);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rsp_err", rsp_err, 0);
        chk("post_busy", busy, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_outs", {rsp_valid, rsp_data, rsp_z, rsp_n, rsp_err, busy}, 0);
        chk("rst_alu", {alu_add, alu_inc, alu_neg, alu_sub, alu_a, alu_b}, 0);
        @(negedge clk); rst_n = 1'b1;

        run_cmd(3'd0, 8'h7F, 8'h01, 0, 0);
        run_cmd(3'd1, 8'h05, 8'h05, 0, 0);
        run_cmd(3'd2, 8'h33, 8'hFF, 0, 0);
        run_cmd(3'd3, 8'h01, 8'h9C, 0, 0);
        run_cmd(3'd4, 8'd13, 8'd11, 0, 0);
        run_cmd(3'd4, 8'h10, 8'h10, 0, 0);
        run_cmd(3'd4, 8'h5A, 8'h00, 0, 0);
        run_cmd(3'd0, 8'h03, 8'h04, 5, 1);
        run_cmd(3'd6, 8'h12, 8'h34, 1, 0);
        run_cmd(3'd0, 8'h20, 8'h22, 0, 0);

        // reset in the middle of a MUL
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'd13; cmd_b = 8'd11;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {rsp_valid, busy, alu_add, alu_a, alu_b, rsp_data}, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        @(negedge clk); rst_n = 1'b1;
        run_cmd(3'd0, 8'h01, 8'h01, 0, 0);

        for (int k = 0; k < 40; k++)
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
